// File: rtl/mul_somador_sweep.sv
// mul_somador_sweep: sweeps all 16 (A,B) pairs into the mulSomador datapath.
// Accumulates Z with sticky carry-out; optional max tracking via SWEEP_MAX_EN.
module mul_somador_sweep #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       z_in,
`ifdef SWEEP_MAX_EN
  output logic [6:0]       z_max,
  output logic [1:0]       max_a,
  output logic [1:0]       max_b,
`endif
  output logic [1:0]       a_out,
  output logic [1:0]       b_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       idx_nxt;
  logic [1:0]       a_q, a_d;
  logic [1:0]       b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

`ifdef SWEEP_MAX_EN
  logic [6:0] zmax_q, zmax_d;
  logic [1:0] maxa_q, maxa_d;
  logic [1:0] maxb_q, maxb_d;
`endif

  // Widen z_in to the carry-inclusive accumulator width.
  assign sum     = {1'b0, acc_q} + {{(ACC_W-6){1'b0}}, z_in};
  assign idx_nxt = idx_q + 4'd1;

  // Next-state, operand sequencing and accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`ifdef SWEEP_MAX_EN
    zmax_d  = zmax_q;
    maxa_d  = maxa_q;
    maxb_d  = maxb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          a_d     = 2'd0;
          b_d     = 2'd0;
          acc_d   = '0;
          ovf_d   = 1'b0;
`ifdef SWEEP_MAX_EN
          zmax_d  = 7'd0;
          maxa_d  = 2'd0;
          maxb_d  = 2'd0;
`endif
        end
      end
      S_RUN: begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_q | sum[ACC_W];
`ifdef SWEEP_MAX_EN
        if (z_in > zmax_q) begin
          zmax_d = z_in;
          maxa_d = a_q;
          maxb_d = b_q;
        end
`endif
        idx_d = idx_nxt;
        if (idx_q == 4'd15) begin
          state_d = S_DONE;
          a_d     = 2'd0;
          b_d     = 2'd0;
        end else begin
          a_d = idx_nxt[3:2];
          b_d = idx_nxt[1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      a_q     <= 2'd0;
      b_q     <= 2'd0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SWEEP_MAX_EN
  // Maximum-Z tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zmax_q <= 7'd0;
      maxa_q <= 2'd0;
      maxb_q <= 2'd0;
    end else begin
      zmax_q <= zmax_d;
      maxa_q <= maxa_d;
      maxb_q <= maxb_d;
    end
  end

  assign z_max = zmax_q;
  assign max_a = maxa_q;
  assign max_b = maxb_q;
`endif

  assign a_out = a_q;
  assign b_out = b_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign acc   = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/mul_somador_sweep.md
# mul_somador_sweep

Sequencer and accumulator that drives the 2-bit A/B operand pair into the mulSomador datapath (Z = A² + 2B² + A·B) and consumes its 7-bit Z result. On a start pulse it sweeps all 16 (A,B) combinations at one pair per clock and accumulates the Z values. It also tracks the maximum Z and the operands that produced it, so a self-check or display stage reads one summary instead of 16 raw results. It sits directly upstream of the datapath for operands and directly downstream of it for Z.

## Interface
Parameters:
- ACC_W, default 12: accumulator width in bits. Legal range is 7 to 16.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep. Sampled only in IDLE.
- a_out  out  2  registered operand A, driven to the datapath.
- b_out  out  2  registered operand B, driven to the datapath.
- z_in  in  7  Z returned from the datapath. It is a combinational function of a_out/b_out.
- busy  out  1  high for the 16 RUN cycles.
- done  out  1  one-cycle pulse when the results are final.
- acc  out  ACC_W  running sum of z_in, with wrap-around.
- ovf  out  1  sticky; set if any addition into acc carries out of ACC_W bits.
- z_max  out  7  largest z_in seen during the sweep (SWEEP_MAX_EN only).
- max_a  out  2  a_out value that produced z_max (SWEEP_MAX_EN only).
- max_b  out  2  b_out value that produced z_max (SWEEP_MAX_EN only).

## Operation
- States: IDLE, RUN, DONE. The index idx is 4 bits, range 0..15.
- IDLE:
  - On start=1: clear acc, ovf, z_max, max_a, max_b and idx; load a_out=0, b_out=0; go to RUN.
  - On start=0: remain in IDLE and hold all results.
- RUN:
  - a_out = idx[3:2] and b_out = idx[1:0] throughout.
  - Every cycle: acc <= acc + z_in, computed in ACC_W+1 bits. The low ACC_W bits are kept. A carry-out sets ovf; ovf is never cleared in RUN.
  - Max tracking: if z_in > z_max (strictly greater), load z_max=z_in, max_a=a_out, max_b=b_out. Ties keep the first occurrence.
  - idx increments each cycle. After sampling idx=15, go to DONE. a_out/b_out return to 0.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start is ignored in DONE.
- start is ignored while in RUN.
- Results (acc, ovf, z_max, max_a, max_b) remain stable from DONE until the next accepted start.
- rst=1 at any time, including mid-RUN:
  - Immediately forces IDLE.
  - Clears idx, a_out, b_out, busy, done, acc, ovf, z_max, max_a and max_b to 0. No partial result is retained.

## Timing
- Reset value of every output is 0.
- Accepted start at edge k:
  - busy=1 from after edge k through edge k+16 (16 cycles).
  - The pair n (n = 0..15) is present on a_out/b_out in the cycle following edge k+n, and z_in is sampled at edge k+n+1.
  - done=1 in the cycle after edge k+16, with all results final.
  - busy=0 from edge k+16 onward.
- Total latency from the start edge to done is 17 cycles.
- z_in must settle within one clock period of a_out/b_out changing. The block adds no input register on z_in.
- The earliest next accepted start is the cycle after done (the block is back in IDLE at edge k+17).

## Configuration
- SWEEP_MAX_EN defined: the z_max, max_a and max_b ports and the max-tracking logic are present, as described above.
- SWEEP_MAX_EN undefined: those three ports and their registers are absent. acc, ovf, busy and done behave identically.

## Test plan
- Reset: assert rst for 2 cycles at time 0 -> every output is 0 and the block is in IDLE. start held at 0 for 20 cycles -> busy stays 0.
- Full sweep (ACC_W=12, reference datapath attached): pulse start -> busy high for 16 cycles, a_out/b_out step (0,0),(0,1)…(3,3), done pulses 17 cycles after start. Final values: acc=204, ovf=0, z_max=36, max_a=3, max_b=3.
- Overflow (ACC_W=7): pulse start -> done occurs with acc=76 and ovf=1. A second start clears ovf to 0 on acceptance.
- Ignored starts: pulse start again at RUN cycle 5 and in the DONE cycle -> the sweep is unaffected (acc=204, done pulses once). A start 1 cycle after done is accepted and reproduces acc=204.
- Reset mid-sweep: assert rst asynchronously at RUN cycle 8 -> all outputs are 0 immediately, without waiting for a clock edge. Release rst, then pulse start -> full sweep gives acc=204.
- Build without SWEEP_MAX_EN: rerun the full-sweep scenario -> acc=204, ovf=0, done at 17 cycles, and the max ports are absent from the elaborated design.
